priority_bit_iterator: RTL
==========================

PRIORITY_BIT_ITERATOR -- requirements
Module: priority_bit_iterator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the input word width; legal values are 2 and above.
REQ-002 SHALL have parameter IDX_W, default $clog2(WIDTH), the width of the index output.
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port srst_i, input, 1 bit, reset; it is asynchronous and active-high.
REQ-005 SHALL have port data_i, input, WIDTH bits, the word to scan.
REQ-006 SHALL have port msb_first_i, input, 1 bit, scan order (1 = MSB first, 0 = LSB first); it is sampled with data_i.
REQ-007 SHALL have port data_val_i, input, 1 bit, input valid.
REQ-008 SHALL have port data_ready_o, output, 1 bit, input ready.
REQ-009 SHALL have port onehot_o, output, WIDTH bits, the selected set bit in one-hot form.
REQ-010 SHALL have port index_o, output, IDX_W bits, the binary position of the selected bit.
REQ-011 SHALL have port last_o, output, 1 bit, marking the final beat of the current word.
REQ-012 SHALL have port empty_o, output, 1 bit, set when the accepted word was all zeros.
REQ-013 SHALL have port data_val_o, output, 1 bit, output valid.
REQ-014 SHALL have port data_ready_i, input, 1 bit, downstream ready.

Function
REQ-015 SHALL implement a two-state FSM with states IDLE and ITER.
REQ-016 SHALL drive data_ready_o = 1 only in IDLE.
REQ-017 SHALL accept a word when data_val_i & data_ready_o; on acceptance it latches data_i into a residual register, latches msb_first_i, and moves to ITER.
REQ-018 SHALL ignore data_val_i while in ITER; the word and mode in flight are unaffected.
REQ-019 SHALL assert data_val_o exactly while in ITER; the first beat is valid the cycle after acceptance (latency 1).
REQ-020 SHALL, on each beat with a nonzero residual, select the highest set bit when mode = 1 and the lowest set bit when mode = 0.
- onehot_o = the selected bit; index_o = its position.
- last_o = 1 when the residual has exactly one bit set; empty_o = 0.
REQ-021 SHALL, on each beat with a zero residual, produce exactly one beat: onehot_o = 0, index_o = 0, last_o = 1, empty_o = 1.
REQ-022 SHALL treat a beat as transferred on data_val_o & data_ready_i; on transfer it clears the selected bit from the residual.
REQ-023 SHALL return to IDLE on the transfer of a beat with last_o = 1.
REQ-024 SHALL hold onehot_o, index_o, last_o and empty_o stable while data_val_o & !data_ready_i (stall).
REQ-025 SHALL emit exactly max(popcount(word), 1) beats per word, strictly in priority order with no repeats.
REQ-026 SHALL sustain a throughput of one accepted word per max(popcount, 1) + 1 cycles with data_ready_i held high.
REQ-027 SHALL select the priority bit with combinational logic over the registered residual; output fields may be registered or combinational from registered state, but SHALL have no combinational path from data_ready_i to any output.
REQ-028 SHALL index bits as position 0 = LSB and WIDTH-1 = MSB for every WIDTH.

Reset
REQ-029 SHALL, while srst_i = 1, immediately force: state IDLE, residual 0, data_val_o 0, onehot_o 0, index_o 0, last_o 0, empty_o 0, data_ready_o 1.
REQ-030 SHALL, when srst_i is asserted mid-word, discard the remaining beats; no beat of that word appears after srst_i is released.
REQ-031 SHALL accept a new word on the first rising edge after srst_i is released if data_val_i = 1.

Verification
REQ-032 SHALL cover: WIDTH=8, 8'b01001000, msb_first=1, data_ready_i=1 -> beats (01000000, idx 6, last 0) then (00001000, idx 3, last 1); data_ready_o low for 2 cycles.
REQ-033 SHALL cover: the same word with msb_first=0 -> beats idx 3 then idx 6, last_o set on the idx-6 beat.
REQ-034 SHALL cover: 8'h00 -> a single beat with onehot 0, idx 0, empty 1, last 1; back in IDLE the next cycle.
REQ-035 SHALL cover: 8'hFF, msb_first=1, data_ready_i toggling 1/0, data_val_i pulsed with 8'hAA mid-word -> 8 beats idx 7..0, outputs held through every stall, 8'hAA not accepted.
REQ-036 SHALL cover: 8'b00100010, srst_i asserted for 1 cycle after the first beat transfers -> outputs 0 asynchronously, data_ready_o = 1, the idx-1 beat never appears.
REQ-037 SHALL cover: WIDTH=16, 16'h8001, msb_first=0 -> beats idx 0 then idx 15; index_o is 4 bits wide.

Source files
------------

// File: rtl/priority_bit_iterator.sv
// Walks the set bits of an accepted word one beat at a time, highest-first or lowest-first.
// An all-zero word yields a single empty beat.
module priority_bit_iterator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             msb_first_i,
  input  logic             data_val_i,
  output logic             data_ready_o,
  output logic [WIDTH-1:0] onehot_o,
  output logic [IDX_W-1:0] index_o,
  output logic             last_o,
  output logic             empty_o,
  output logic             data_val_o,
  input  logic             data_ready_i
);

  typedef enum logic [0:0] {StIdle, StIter} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] residual_q, residual_d;
  logic             mode_q, mode_d;

  logic [WIDTH-1:0] sel_onehot;
  logic [IDX_W-1:0] sel_idx;
  logic             res_zero;
  logic             res_single;
  logic             in_iter;
  logic             beat_last;

  // Priority pick over the registered residual; the last hit in scan order wins.
  always_comb begin
    sel_onehot = '0;
    sel_idx    = '0;
    if (mode_q) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (residual_q[i]) begin
          sel_onehot    = '0;
          sel_onehot[i] = 1'b1;
          sel_idx       = IDX_W'(i);
        end
      end
    end else begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (residual_q[i]) begin
          sel_onehot    = '0;
          sel_onehot[i] = 1'b1;
          sel_idx       = IDX_W'(i);
        end
      end
    end
  end

  assign res_zero   = (residual_q == '0);
  assign res_single = !res_zero && ((residual_q & (residual_q - WIDTH'(1))) == '0);
  assign in_iter    = (state_q == StIter);
  assign beat_last  = res_zero | res_single;

  // Outputs depend only on registered state, so they settle to idle values as soon as
  // the asynchronous reset clears the registers.
  assign data_ready_o = !in_iter;
  assign data_val_o   = in_iter;
  assign onehot_o     = in_iter ? sel_onehot : '0;
  assign index_o      = in_iter ? sel_idx : '0;
  assign last_o       = in_iter & beat_last;
  assign empty_o      = in_iter & res_zero;

  always_comb begin
    state_d    = state_q;
    residual_d = residual_q;
    mode_d     = mode_q;
    unique case (state_q)
      StIdle: begin
        if (data_val_i) begin
          residual_d = data_i;
          mode_d     = msb_first_i;
          state_d    = StIter;
        end
      end
      StIter: begin
        if (data_ready_i) begin
          residual_d = residual_q & ~sel_onehot;
          if (beat_last) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q    <= StIdle;
      residual_q <= '0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      residual_q <= residual_d;
      mode_q     <= mode_d;
    end
  end

endmodule
